// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between a controller and shift_sequencer.
// Latency: none, wires only.
// Backpressure: start/ready on the request side, result_valid/result_ack on the result side.
//
// Signals:
//   start, operand, amount, mode : request, accepted when start && ready
//   ready                        : sequencer idle and able to accept
//   result, result_valid         : shifted value, held until result_ack
//   result_ack                   : consumer takes the result
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             mode;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ack;

    // Controller / test side
    modport master (
        output start, operand, amount, mode, result_ack,
        input  ready, result, result_valid
    );

    // Sequencer side
    modport slave (
        input  start, operand, amount, mode, result_ack,
        output ready, result, result_valid
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit right-shift sequencer driving an external one-position-per-cycle shifter.
// Latency: amount N>0 -> result_valid from cycle N+1 after acceptance; amount 0 -> cycle 1.
// Backpressure: ready only in IDLE; DONE holds result indefinitely until result_ack.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : start/operand/amount/mode request, result/result_valid/result_ack reply
//   sh_enable/sh_in/sh_mode : drive the shifter; sh_out is its registered output
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    shift_sequencer_if.slave   bus,
    output logic               sh_enable,
    output logic [WIDTH-1:0]   sh_in,
    output logic               sh_mode,
    input  logic [WIDTH-1:0]   sh_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] op_reg_q,    op_reg_d;
    logic [AMT_W-1:0] amt_reg_q,   amt_reg_d;
    logic             mode_reg_q,  mode_reg_d;
    logic [AMT_W-1:0] cnt_q,       cnt_d;
    logic             zero_flag_q, zero_flag_d;

    // Shifting WIDTH or more positions gives the same answer as WIDTH, so
    // clamp once at acceptance and never run the shifter longer than needed.
    logic [AMT_W-1:0] eff_amt;
    assign eff_amt = (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;

    always_comb begin
        state_d     = state_q;
        op_reg_d    = op_reg_q;
        amt_reg_d   = amt_reg_q;
        mode_reg_d  = mode_reg_q;
        cnt_d       = cnt_q;
        zero_flag_d = zero_flag_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_reg_d   = bus.operand;
                    mode_reg_d = bus.mode;
                    amt_reg_d  = eff_amt;
                    cnt_d      = '0;
                    if (eff_amt == '0) begin
                        // Nothing to shift: present the operand directly.
                        zero_flag_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        zero_flag_d = 1'b0;
                        state_d     = SHIFT;
                    end
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + AMT_ONE;
                // amt_reg_q is at least 1 here, so the subtraction cannot wrap.
                if (cnt_q == amt_reg_q - AMT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.result_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_reg_q    <= '0;
            amt_reg_q   <= '0;
            mode_reg_q  <= 1'b0;
            cnt_q       <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_reg_q    <= op_reg_d;
            amt_reg_q   <= amt_reg_d;
            mode_reg_q  <= mode_reg_d;
            cnt_q       <= cnt_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    assign bus.ready        = (state_q == IDLE);
    assign bus.result_valid = (state_q == DONE);
    // The shifter holds in DONE (enable low), so sh_out is stable while valid.
    assign bus.result       = (state_q != DONE) ? '0 :
                              (zero_flag_q ? op_reg_q : sh_out);

    assign sh_enable = (state_q == SHIFT);
    assign sh_mode   = mode_reg_q;
    // First enabled cycle loads the operand; later cycles feed the shifter back on itself.
    assign sh_in     = ((state_q == SHIFT) && (cnt_q != '0)) ? sh_out : op_reg_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    localparam int WIDTH = 16;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             sh_enable;
    logic             sh_mode;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_out = '0;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sh_enable (sh_enable),
        .sh_in     (sh_in),
        .sh_mode   (sh_mode),
        .sh_out    (sh_out)
    );

    always #5 clk = ~clk;

    // Behavioural right_shift_register: one position per enabled cycle, no reset.
    always @(posedge clk) begin
        if (sh_enable) begin
            sh_out <= sh_mode ? {1'b0, sh_in[WIDTH-1:1]} : {sh_in[WIDTH-1], sh_in[WIDTH-1:1]};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] op, input int amt, input logic m);
        int eff;
        eff = (amt > WIDTH) ? WIDTH : amt;
        if (m) return op >> eff;
        return WIDTH'($signed(op) >>> eff);
    endfunction

    task automatic run_op(input string name, input logic [WIDTH-1:0] op, input int amt,
                          input logic m, input int hold);
        int eff;
        int en_cnt;
        int vcyc;
        logic [WIDTH-1:0] exp;
        eff = (amt > WIDTH) ? WIDTH : amt;
        @(negedge clk);
        check({name, "/ready_pre"}, 32'(bus.ready), 32'd1);
        bus.start   = 1'b1;
        bus.operand = op;
        bus.amount  = AMT_W'(amt);
        bus.mode    = m;
        exp_q.push_back(model(op, amt, m));
        @(posedge clk);
        #1;
        // Keep start high with different request fields while busy; all must be ignored.
        bus.operand = ~op;
        bus.amount  = AMT_W'(1);
        bus.mode    = ~m;
        en_cnt = 0;
        vcyc   = 0;
        for (int c = 1; c <= 40 && vcyc == 0; c++) begin
            @(negedge clk);
            if (sh_enable) en_cnt++;
            if (bus.result_valid) vcyc = c;
        end
        bus.start = 1'b0;
        check({name, "/enable_cycles"}, 32'(en_cnt), 32'(eff));
        check({name, "/valid_cycle"}, 32'(vcyc), 32'(eff + 1));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({name, "/result"}, 32'(bus.result), 32'(exp));
        check({name, "/ready_busy"}, 32'(bus.ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.start      = h[0];
            bus.operand    = WIDTH'($urandom);
            bus.result_ack = 1'b0;
            @(negedge clk);
            check({name, "/hold_result"}, 32'(bus.result), 32'(exp));
            check({name, "/hold_valid"}, 32'(bus.result_valid), 32'd1);
            check({name, "/hold_ready"}, 32'(bus.ready), 32'd0);
            check({name, "/hold_enable"}, 32'(sh_enable), 32'd0);
        end
        bus.start      = 1'b0;
        bus.result_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ack = 1'b0;
        @(negedge clk);
        check({name, "/ready_after_ack"}, 32'(bus.ready), 32'd1);
        check({name, "/valid_after_ack"}, 32'(bus.result_valid), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.operand    = '0;
        bus.amount     = '0;
        bus.mode       = 1'b0;
        bus.result_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset/ready", 32'(bus.ready), 32'd1);
        check("reset/valid", 32'(bus.result_valid), 32'd0);
        check("reset/enable", 32'(sh_enable), 32'd0);
        check("reset/result", 32'(bus.result), 32'd0);

        // Stray ack in IDLE does nothing.
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check("idle_ack/ready", 32'(bus.ready), 32'd1);
        check("idle_ack/valid", 32'(bus.result_valid), 32'd0);

        run_op("arith3",   16'h8000, 3,  1'b0, 0);
        run_op("logic3",   16'h8000, 3,  1'b1, 0);
        run_op("zero_a",   16'h1234, 0,  1'b0, 0);
        run_op("zero_l",   16'h1234, 0,  1'b1, 0);
        run_op("clamp_a",  16'h8001, 20, 1'b0, 0);
        run_op("clamp_l",  16'h8001, 20, 1'b1, 0);
        run_op("full_a",   16'h4000, 16, 1'b0, 0);
        run_op("hold",     16'hC3A5, 5,  1'b0, 10);
        run_op("odd_l",    16'hBEEF, 7,  1'b1, 0);

        // Reset during the second SHIFT cycle abandons the operation.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = 16'hAAAA;
        bus.amount  = AMT_W'(5);
        bus.mode    = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst/shift_c1", 32'(sh_enable), 32'd1);
        @(negedge clk);
        check("rst/shift_c2", 32'(sh_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst/ready", 32'(bus.ready), 32'd1);
        check("rst/valid", 32'(bus.result_valid), 32'd0);
        check("rst/enable", 32'(sh_enable), 32'd0);
        check("rst/result", 32'(bus.result), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst/no_result", 32'(bus.result_valid), 32'd0);
        end

        run_op("rst_follow", 16'h00F0, 4, 1'b1, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
